// File: rtl/dotacc_pkg.sv
// -----------------------------------------------------------------------------
// dotacc_pkg
// Shared definitions for the dot-product accumulator slice:
//   - state_t           : FSM state encoding (IDLE, ACCUM, DONE)
//   - default_*         : default widths for the accumulator block
//   - max_unsigned()    : largest unsigned value representable in w bits
// -----------------------------------------------------------------------------
package dotacc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int default_width     = 8;
  localparam int default_acc_width = 18;
  localparam int default_len_width = 8;

  // Returns 2^w - 1, clamped to a 64-bit result.
  function automatic logic [63:0] max_unsigned(input int w);
    if (w >= 64) begin
      return '1;
    end
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/dotacc_sat_add.sv
// -----------------------------------------------------------------------------
// dotacc_sat_add
// Combinational accumulator adder. Adds the zero-extended product to the
// accumulator at acc_width+1 bits and reports the carry out of the top bit.
// Build option: DOTACC_SATURATE_EN -- when defined, a carry clamps the sum to
// 2^acc_width - 1; when undefined, the sum wraps modulo 2^acc_width.
//
// Ports:
//   acc      in  [acc_width-1:0]  current accumulator value
//   product  in  [2*width-1:0]    unsigned term to add
//   sum      out [acc_width-1:0]  next accumulator value (wrapped or clamped)
//   carry    out                  addition exceeded 2^acc_width - 1
// -----------------------------------------------------------------------------
module dotacc_sat_add
  import dotacc_pkg::*;
#(
  parameter int width     = default_width,
  parameter int acc_width = default_acc_width
) (
  input  logic [acc_width-1:0] acc,
  input  logic [2*width-1:0]   product,
  output logic [acc_width-1:0] sum,
  output logic                 carry
);

`ifdef DOTACC_SATURATE_EN
  localparam logic [acc_width-1:0] sat_value = acc_width'(max_unsigned(acc_width));
`endif

  logic [acc_width:0] raw;

  always_comb begin
    // NOTE: every output of this block is assigned before any conditional
    // override, so no path leaves a value unassigned and no latch is inferred.
    raw   = {1'b0, acc} + (acc_width + 1)'(product);
    carry = raw[acc_width];
    sum   = raw[acc_width-1:0];
`ifdef DOTACC_SATURATE_EN
    // Once clamped, later non-zero terms carry again and stay clamped.
    if (carry) begin
      sum = sat_value;
    end
`endif
  end

endmodule

// File: rtl/dot_product_accumulator.sv
// -----------------------------------------------------------------------------
// dot_product_accumulator
// Sums a programmed number of unsigned multiplier products and presents the
// total on a valid/ready output. Build option: DOTACC_SATURATE_EN selects
// saturating (defined) or wrapping (undefined) accumulation; overflow is a
// sticky flag in both builds.
//
// Ports:
//   clk        in               rising-edge clock
//   rst        in               synchronous reset, active-high
//   start      in               begin a job (honoured only when idle)
//   length     in  [len_width]  number of terms, sampled with start
//   in_valid   in               product holds a valid term
//   in_ready   out              block accepts a term this cycle
//   product    in  [2*width]    unsigned term from the multiplier
//   out_valid  out              result is valid
//   out_ready  in               downstream accepts result
//   result     out [acc_width]  accumulated sum
//   overflow   out              a carry occurred during this job
//   busy       out              not idle
// -----------------------------------------------------------------------------
module dot_product_accumulator
  import dotacc_pkg::*;
#(
  parameter int width     = default_width,
  parameter int acc_width = default_acc_width,
  parameter int len_width = default_len_width
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [len_width-1:0] length,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*width-1:0]   product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [acc_width-1:0] result,
  output logic                 overflow,
  output logic                 busy
);

  localparam logic [len_width-1:0] one_term = len_width'(1);

  state_t               state;
  logic [len_width-1:0] remaining;
  logic [acc_width-1:0] next_sum;
  logic                 carry;

  dotacc_sat_add #(
    .width    (width),
    .acc_width(acc_width)
  ) u_add (
    .acc    (result),
    .product(product),
    .sum    (next_sum),
    .carry  (carry)
  );

  // Outputs are registered together with the state so in_ready, out_valid and
  // busy are pure functions of the current state, never of same-cycle inputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is checked first and overrides all inputs.
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      result    <= '0;
      overflow  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            result    <= '0;
            overflow  <= 1'b0;
            remaining <= length;
            busy      <= 1'b1;
            if (length != '0) begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (in_valid) begin
            result    <= next_sum;
            overflow  <= overflow | carry;
            remaining <= remaining - one_term;
            if (remaining == one_term) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_dot_product_accumulator
// Self-checking bench. A behavioural multiplier stands in upstream and feeds
// product = a * b. Expected sums come from a plain-arithmetic model of the
// whole job (total of all products, then wrap or clamp).
// -----------------------------------------------------------------------------
module tb_dot_product_accumulator;

  localparam int     width     = 8;
  localparam int     acc_width = 18;
  localparam int     len_width = 8;
  localparam longint acc_max   = (longint'(1) << acc_width) - 1;

  logic                 clk       = 1'b0;
  logic                 rst       = 1'b1;
  logic                 start     = 1'b0;
  logic [len_width-1:0] length    = '0;
  logic                 in_valid  = 1'b0;
  logic                 out_ready = 1'b0;
  logic [width-1:0]     mul_a     = '0;
  logic [width-1:0]     mul_b     = '0;
  logic [2*width-1:0]   product;
  logic                 in_ready;
  logic                 out_valid;
  logic                 overflow;
  logic                 busy;
  logic [acc_width-1:0] result;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned op_a[64];
  int unsigned op_b[64];

  always #5 clk = ~clk;

  // Upstream multiplier stand-in.
  assign product = (2*width)'(mul_a) * (2*width)'(mul_b);

  dot_product_accumulator #(
    .width    (width),
    .acc_width(acc_width),
    .len_width(len_width)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .length   (length),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .product  (product),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow),
    .busy     (busy)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Whole-job reference: total of all products, then clamp or wrap.
  function automatic void model(input int n, output longint res, output bit ovf);
    longint total = 0;
    for (int i = 0; i < n; i++) begin
      total += longint'(op_a[i]) * longint'(op_b[i]);
    end
    ovf = (total > acc_max);
`ifdef DOTACC_SATURATE_EN
    res = ovf ? acc_max : total;
`else
    res = total % (acc_max + 1);
`endif
  endfunction

  // Runs one job using op_a/op_b[0..n-1]. Called at a negedge; returns at the
  // negedge after the output handshake, so a following call starts back-to-back.
  task automatic run_job(input string tag, input int n, input bit gaps,
                         input int hold, input bit mid_start,
                         input longint fixed_res, input int fixed_ovf);
    longint               exp_res;
    bit                   exp_ovf;
    int                   idx       = 0;
    int                   cyc       = 0;
    int                   gap_left;
    bit                   ready_ok  = 1'b1;
    bit                   quiet_ok  = 1'b1;
    bit                   stable_ok = 1'b1;
    logic [acc_width-1:0] held;

    model(n, exp_res, exp_ovf);
    gap_left = gaps ? 3 : 0;

    start  = 1'b1;
    length = len_width'(n);
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, longint'(busy), 1);

    while (idx < n && cyc < 500) begin
      if (!in_ready)  ready_ok = 1'b0;
      if (out_valid)  quiet_ok = 1'b0;
      if (gap_left > 0 && idx > 0 && (idx == n - 1 || $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        mul_a    = width'($urandom);
        mul_b    = width'($urandom);
        gap_left--;
      end else begin
        in_valid = 1'b1;
        mul_a    = width'(op_a[idx]);
        mul_b    = width'(op_b[idx]);
      end
      if (mid_start && idx == 1) begin
        start  = 1'b1;
        length = len_width'(200);
      end
      @(negedge clk);
      start = 1'b0;
      if (in_valid) idx++;
      cyc++;
    end
    in_valid = 1'b0;

    check({tag, " beats_within_budget"}, idx, n);
    check({tag, " out_valid"}, longint'(out_valid), 1);
    check({tag, " in_ready_low_in_done"}, longint'(in_ready), 0);
    check({tag, " result"}, longint'(result), exp_res);
    check({tag, " overflow"}, longint'(overflow), longint'(exp_ovf));
    if (n > 0) begin
      check({tag, " in_ready_held"}, longint'(ready_ok), 1);
      check({tag, " no_early_out_valid"}, longint'(quiet_ok), 1);
    end
    if (fixed_res >= 0) check({tag, " result_const"}, longint'(result), fixed_res);
    if (fixed_ovf >= 0) check({tag, " overflow_const"}, longint'(overflow), longint'(fixed_ovf));

    // Back-pressure: hold result while start is pulsed and must be ignored.
    held      = result;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start  = 1'b1;
      length = len_width'(3);
      @(negedge clk);
      if (!out_valid || result != held) stable_ok = 1'b0;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (hold > 0) check({tag, " held_stable"}, longint'(stable_ok), 1);
    check({tag, " idle_busy"}, longint'(busy), 0);
    check({tag, " idle_out_valid"}, longint'(out_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     n;
    longint ovf_res;

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset in_ready", longint'(in_ready), 0);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset result", longint'(result), 0);
    check("reset overflow", longint'(overflow), 0);
    check("reset busy", longint'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Four fixed terms on consecutive cycles, then with gaps.
    op_a[0] = 15;  op_b[0] = 10;
    op_a[1] = 25;  op_b[1] = 40;
    op_a[2] = 100; op_b[2] = 3;
    op_a[3] = 255; op_b[3] = 255;
    run_job("basic", 4, 1'b0, 0, 1'b0, 66475, 0);
    run_job("gaps", 4, 1'b1, 0, 1'b0, 66475, 0);

    // Five maximal terms overflow an 18-bit accumulator.
    for (int i = 0; i < 5; i++) begin
      op_a[i] = 255;
      op_b[i] = 255;
    end
`ifdef DOTACC_SATURATE_EN
    ovf_res = 262143;
`else
    ovf_res = 62981;
`endif
    run_job("overflow", 5, 1'b0, 0, 1'b0, ovf_res, 1);

    // Zero-length job with five cycles of back-pressure.
    run_job("zero_len", 0, 1'b0, 5, 1'b0, 0, 0);

    // Reset in the middle of a job.
    for (int i = 0; i < 4; i++) begin
      op_a[i] = $urandom_range(1, 255);
      op_b[i] = $urandom_range(1, 255);
    end
    start  = 1'b1;
    length = len_width'(4);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      mul_a    = width'(op_a[i]);
      mul_b    = width'(op_b[i]);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midreset busy", longint'(busy), 0);
    check("midreset out_valid", longint'(out_valid), 0);
    check("midreset result", longint'(result), 0);
    check("midreset in_ready", longint'(in_ready), 0);
    check("midreset overflow", longint'(overflow), 0);
    op_a[0] = 0;
    op_b[0] = 123;
    run_job("after_reset", 1, 1'b0, 0, 1'b0, 0, 0);

    // Back-to-back jobs with a start pulse injected during ACCUM.
    for (int i = 0; i < 6; i++) begin
      op_a[i] = $urandom_range(0, 255);
      op_b[i] = $urandom_range(0, 255);
    end
    run_job("b2b_first", 6, 1'b0, 0, 1'b1, -1, -1);
    run_job("b2b_second", 3, 1'b0, 0, 1'b0, -1, -1);

    // Randomized jobs; the last ones use large operands to force carries.
    for (int j = 0; j < 10; j++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        op_a[i] = (j >= 7) ? $urandom_range(200, 255) : $urandom_range(0, 255);
        op_b[i] = (j >= 7) ? $urandom_range(200, 255) : $urandom_range(0, 255);
      end
      run_job($sformatf("rand%0d", j), n, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), (n >= 2) && ($urandom_range(0, 1) == 1), -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
